// File: rtl/sma_v1.sv
// sma_v1: signed 32-bit simple moving average over 2^sel samples, ring buffer + running sum.
// SMA_DEBUG_EN drives the m_* monitor ports; undefined ties them to 0.
module sma_v1 #(
  parameter int WINDOW_SIZE = 8192
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data,
  input  logic        i_update_strobe,
  input  logic [31:0] i_window_sel,
  output logic [31:0] o_data,
  output logic [31:0] m_count_reg,
  output logic [63:0] m_sum_reg,
  output logic [15:0] m_N,
  output logic [31:0] m_data_reg
);
  localparam int LW = $clog2(WINDOW_SIZE);
  logic [31:0]        r_ram [WINDOW_SIZE];
  logic [LW-1:0]      r_wp;
  logic [4:0]         r_sel, w_sel;
  logic [16:0]        w_n;
  logic               r_stb, r_v1, r_v2, r_v3, w_acc, w_chg, w_full;
  logic [31:0]        r_x, r_rd, r_old, r_cnt, r_data, r_out;
  logic signed [63:0] r_sum;
  logic               w_unused;
  assign w_sel  = (i_window_sel[4:0] > 5'(LW)) ? 5'(LW) : i_window_sel[4:0];
  assign w_chg  = w_sel != r_sel;
  assign w_n    = 17'd1 << r_sel;
  assign w_full = r_cnt == 32'(w_n);
  // a new edge is taken only when idle and the window is stable
  assign w_acc  = i_update_strobe && !r_stb && !(r_v1 || r_v2 || r_v3) && !w_chg;
  assign o_data = r_out;
  // RAM: read of the outgoing sample at acceptance, write one cycle later (old-data semantics)
  always_ff @(posedge i_clk) begin
    if (w_acc) r_rd <= r_ram[r_wp - LW'(w_n)];
    if (r_v1 && !w_chg) r_ram[r_wp] <= r_x;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stb  <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_x    <= '0;
      r_data <= '0;
      r_old  <= '0;
      r_sel  <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_out  <= '0;
    end else begin
      r_stb <= i_update_strobe;
      r_v1  <= w_acc;
      r_v2  <= r_v1 && !w_chg;
      r_v3  <= r_v2 && !w_chg;
      if (w_acc) begin
        r_x    <= i_data;
        r_data <= i_data;
      end
      if (r_v1) r_old <= w_full ? r_rd : '0;
      if (w_chg) begin
        r_sel <= w_sel;
        r_sum <= '0;
        r_cnt <= '0;
        r_wp  <= '0;
      end else if (r_v2) begin
        r_sum <= r_sum + {{32{r_x[31]}}, r_x} - {{32{r_old[31]}}, r_old};
        r_cnt <= w_full ? r_cnt : r_cnt + 1;
        r_wp  <= r_wp + LW'(1);
      end
      if (r_v3) r_out <= 32'(r_sum >>> r_sel);
    end
  end
`ifdef SMA_DEBUG_EN
  assign m_count_reg = r_cnt;
  assign m_sum_reg   = r_sum;
  assign m_N         = 16'd1 << w_sel;
  assign m_data_reg  = r_data;
  assign w_unused    = ^i_window_sel[31:5];
`else
  assign m_count_reg = '0;
  assign m_sum_reg   = '0;
  assign m_N         = '0;
  assign m_data_reg  = '0;
  assign w_unused    = ^{i_window_sel[31:5], r_data};
`endif
endmodule

// File: tb/tb_sma_v1.sv
// tb_sma_v1: randomized scoreboard bench for sma_v1 against a window-queue reference model.
module tb_sma_v1;
`ifdef SMA_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0;
  logic [31:0] din = '0, sel_in = 32'd2;
  logic [31:0] o_data, m_count_reg, m_data_reg;
  logic [63:0] m_sum_reg;
  logic [15:0] m_N;
  int cyc = 0, total = 0, bad = 0;

  typedef struct {
    int          due;
    logic [31:0] o;
    logic [31:0] cnt;
    logic [63:0] sum;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  logic [31:0] win[$];
  int msel = 0;

  sma_v1 dut (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_update_strobe(stb),
    .i_window_sel(sel_in), .o_data(o_data), .m_count_reg(m_count_reg),
    .m_sum_reg(m_sum_reg), .m_N(m_N), .m_data_reg(m_data_reg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int eff_sel(input logic [31:0] s);
    return (s[4:0] > 5'd13) ? 13 : int'(s[4:0]);
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0 && cyc >= q[0].due) begin
      exp_t e;
      e = q.pop_front();
      chk("o_data", {32'd0, o_data}, {32'd0, e.o});
      chk("m_count_reg", {32'd0, m_count_reg}, {32'd0, e.cnt});
      chk("m_sum_reg", m_sum_reg, e.sum);
      chk("m_data_reg", {32'd0, m_data_reg}, {32'd0, e.d});
    end
  end

  task automatic set_sel(input logic [31:0] s);
    int n;
    @(negedge clk);
    sel_in = s;
    if (eff_sel(s) != msel) begin
      win.delete();
      msel = eff_sel(s);
    end
    n = 1 << msel;
    #1 chk("m_N", {48'd0, m_N}, {48'd0, (DBG ? n[15:0] : 16'd0)});
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] x, input int h);
    exp_t e;
    longint s, qq;
    int n;
    @(negedge clk);
    din = x;
    stb = 1'b1;
    n = 1 << msel;
    win.push_back(x);
    if (win.size() > n) void'(win.pop_front());
    s = 0;
    foreach (win[i]) s += longint'($signed(win[i]));
    qq = s / n;
    if ((s % n) != 0 && s < 0) qq--;
    e.due = cyc + 4;
    e.o = 32'(qq);
    e.cnt = DBG ? 32'(win.size()) : 32'd0;
    e.sum = DBG ? 64'(s) : 64'd0;
    e.d = DBG ? x : 32'd0;
    q.push_back(e);
    repeat (h) @(negedge clk);
    stb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst o_data", {32'd0, o_data}, 64'd0);
    chk("rst m_count_reg", {32'd0, m_count_reg}, 64'd0);
    chk("rst m_sum_reg", m_sum_reg, 64'd0);
    chk("rst m_data_reg", {32'd0, m_data_reg}, 64'd0);
    rst = 1'b0;
    win.delete();
    msel = 0;
  endtask

  initial begin
    do_reset();
    set_sel(32'd2);
    for (int i = 0; i < 6; i++) send(32'd100, 1);
    set_sel(32'd3);
    for (int i = 0; i < 4; i++) send(32'd100, 1);
    do_reset();
    set_sel(32'd3);
    for (int i = 0; i < 10; i++) send(-32'sd8, (i == 3) ? 8 : 1);
    // randomized windows, data and strobe widths; upper select bits are noise
    for (int r = 0; r < 6; r++) begin
      set_sel(($urandom() & ~32'd31) | 32'($urandom_range(0, 5)));
      for (int i = 0; i < 40; i++)
        send((i % 13 == 0) ? 32'h8000_0000 : (i % 17 == 0) ? 32'h7fff_ffff : $urandom(), $urandom_range(1, 3));
    end
    // abort a sample mid-pipeline with an asynchronous reset
    @(negedge clk);
    din = 32'd555;
    stb = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async o_data", {32'd0, o_data}, 64'd0);
    chk("async m_count_reg", {32'd0, m_count_reg}, 64'd0);
    chk("async m_sum_reg", m_sum_reg, 64'd0);
    chk("async m_data_reg", {32'd0, m_data_reg}, 64'd0);
    do_reset();
    set_sel(32'd2);
    send(32'd100, 1);
    send(32'd100, 1);
    // largest window: select clamps to 13, full ring exercises read-before-write
    set_sel(32'd20);
    for (int i = 0; i < 8192; i++) send(32'd1, 1);
    for (int i = 0; i < 6; i++) send($urandom_range(0, 1000), 1);
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expected outputs never checked, required 0", q.size());
      bad += q.size();
      total += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
